fwd_bypass_unit: RTL and testbench
==================================

Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the decode stage of the in-order pipeline.
- Keeps a 3-entry in-flight writer scoreboard (E, M, W). Each entry holds valid, rd and is_load.
- For each of NREAD decode read ports, selects the youngest in-flight producer's result or the register-file value.
- Asserts a load-use stall when the youngest producer's data is not yet available.

Parameters:
- XLEN, 32, datapath width.
- NREAD, 2, number of decode source-operand read ports.
- RADDR_W, 5, register address width; address 0 is hard-zero and is never forwarded.
- LOAD_DATA_STAGE, 2, stage whose result carries load data: 2 = M (m_result), 3 = W only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_addr  in  NREAD*RADDR_W  source register addresses, port i at [i*RADDR_W +: RADDR_W].
- rs_re  in  NREAD  per-port read enable.
- reg_rs_data  in  NREAD*XLEN  register-file read data per port.
- d_valid  in  1  valid instruction in D.
- d_rd  in  RADDR_W  D destination register.
- d_reg_write  in  1  D writes rd.
- d_is_load  in  1  D is a load.
- flush_e  in  1  bubble inserted into E this cycle (branch redirect).
- hold  in  1  global pipeline freeze (memory wait).
- e_result  in  XLEN  E-stage ALU result.
- m_result  in  XLEN  M-stage result, including load data if LOAD_DATA_STAGE=2.
- w_data  in  XLEN  writeback data.
- rs_data_out  out  NREAD*XLEN  forwarded operand per port.
- fwd_sel  out  NREAD*2  per port: 0 regfile, 1 E, 2 M, 3 W.
- load_use_stall  out  1  stall D, bubble E.

Behaviour:
- Reset (rst=1 at edge): E, M and W entries cleared to valid=0, rd=0, is_load=0. Outputs are combinational, so after reset fwd_sel=0, rs_data_out=reg_rs_data and load_use_stall=0.
- Entry write: an entry is valid only if its reg_write was set and rd != 0 at capture.
- Shift, when hold=0 and rst=0:
  - W <= M; M <= E.
  - E <= {d_reg_write & d_rd!=0, d_rd, d_is_load} if d_valid & ~load_use_stall & ~flush_e, else the invalid bubble.
- hold=1: all entries keep their values. Forwarding and stall outputs are still evaluated combinationally.
- rst has priority over hold.
- Match for port i, stage s: rs_re[i] & rs_addr_i != 0 & entry_s.valid & entry_s.rd == rs_addr_i.
- Priority is E > M > W > regfile; the youngest match wins.
  - fwd_sel and rs_data_out select e_result, m_result, w_data or reg_rs_data accordingly.
  - No match, rs_re=0 or addr=0: fwd_sel=0 and reg_rs_data is passed through, even for addr 0.
- Stall: load_use_stall=1 iff, for some port, the youngest matching entry is a load in a stage numbered below LOAD_DATA_STAGE (E=1, M=2, W=3).
  - An older matching load shadowed by a younger non-load match does not stall.
  - During a stall, rs_data_out is don't-care to downstream but must still follow the select rules.
- Stall length: LOAD_DATA_STAGE=2 gives 1 bubble cycle. LOAD_DATA_STAGE=3 gives 2 bubbles if back-to-back, 1 if one independent instruction intervenes.
- Simultaneous stall and flush_e: a bubble enters E, with no double effect.
- flush_e does not alter the E, M or W entries already in flight.
- Multiple ports hitting different stages resolve independently. The stall is the OR over ports.
- Latency: forwarding is 0-cycle combinational from inputs to outputs. The scoreboard updates 1 cycle after the D instruction advances.

Test Plan:
- Reset: hold rst 2 cycles with d_valid=1, d_rd=5, then read rs_addr0=5 → fwd_sel0=0, rs_data_out=reg_rs_data, stall=0.
- ALU chain: issue write x5, then next cycle read x5 with e_result=0x1111 → fwd_sel=1, data 0x1111. One cycle later, with m_result=0x2222 → sel 2. Next cycle, with w_data=0x3333 → sel 3.
- Priority: x7 written by two back-to-back instructions, then read x7 → sel=1 (E), never M.
- x0: write rd=0 with reg_write=1, then read x0 → sel=0, passthrough, no stall.
- Load-use:
  - LOAD_DATA_STAGE=2: load x3, then consumer reads x3 → stall=1 exactly 1 cycle, E bubble, then sel=2 with m_result=0xDEAD.
  - LOAD_DATA_STAGE=3: stall for 2 cycles, then sel=3.
- Shadowing and control:
  - Load x4 followed by add x4: a consumer of x4 sees E non-load → no stall, sel=1.
  - hold=1 for 3 cycles freezes the entries.
  - flush_e drops the D write, so a later read sees no match.

Source files
------------

// File: rtl/fwd_bypass_unit.sv
// Decode-stage operand forwarding and load-use hazard detection.
// Tracks in-flight writers in E/M/W and picks the youngest producer per read port.
module fwd_bypass_unit #(
    parameter int XLEN            = 32,
    parameter int NREAD           = 2,
    parameter int RADDR_W         = 5,
    parameter int LOAD_DATA_STAGE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD*RADDR_W-1:0] rs_addr,
    input  logic [NREAD-1:0]         rs_re,
    input  logic [NREAD*XLEN-1:0]    reg_rs_data,
    input  logic                     d_valid,
    input  logic [RADDR_W-1:0]       d_rd,
    input  logic                     d_reg_write,
    input  logic                     d_is_load,
    input  logic                     flush_e,
    input  logic                     hold,
    input  logic [XLEN-1:0]          e_result,
    input  logic [XLEN-1:0]          m_result,
    input  logic [XLEN-1:0]          w_data,
    output logic [NREAD*XLEN-1:0]    rs_data_out,
    output logic [NREAD*2-1:0]       fwd_sel,
    output logic                     load_use_stall
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd;
        logic               is_load;
    } entry_t;

    // A load result is usable once it reaches LOAD_DATA_STAGE (E=1, M=2, W=3).
    localparam bit E_LOAD_STALLS = (LOAD_DATA_STAGE > 1);
    localparam bit M_LOAD_STALLS = (LOAD_DATA_STAGE > 2);

    entry_t           e_q, m_q, w_q;
    entry_t           d_entry;
    logic             d_advance;
    logic [NREAD-1:0] stall_vec;

    always_comb begin
        d_entry.valid   = d_reg_write & (d_rd != '0);
        d_entry.rd      = d_rd;
        d_entry.is_load = d_is_load;
    end

    assign d_advance = d_valid & ~load_use_stall & ~flush_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!hold) begin
            w_q <= m_q;
            m_q <= e_q;
            e_q <= d_advance ? d_entry : '0;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [RADDR_W-1:0] addr;
        logic               active;
        logic               hit_e, hit_m, hit_w;
        logic [1:0]         sel;
        logic [XLEN-1:0]    data;
        logic               stall;

        assign addr   = rs_addr[i*RADDR_W +: RADDR_W];
        assign active = rs_re[i] & (addr != '0);
        assign hit_e  = active & e_q.valid & (e_q.rd == addr);
        assign hit_m  = active & m_q.valid & (m_q.rd == addr);
        assign hit_w  = active & w_q.valid & (w_q.rd == addr);

        // Youngest match wins, so an older load behind a newer ALU write never stalls.
        always_comb begin
            sel   = 2'd0;
            data  = reg_rs_data[i*XLEN +: XLEN];
            stall = 1'b0;
            if (hit_e) begin
                sel   = 2'd1;
                data  = e_result;
                stall = e_q.is_load & E_LOAD_STALLS;
            end else if (hit_m) begin
                sel   = 2'd2;
                data  = m_result;
                stall = m_q.is_load & M_LOAD_STALLS;
            end else if (hit_w) begin
                sel   = 2'd3;
                data  = w_data;
            end
        end

        assign rs_data_out[i*XLEN +: XLEN] = data;
        assign fwd_sel[i*2 +: 2]           = sel;
        assign stall_vec[i]                = stall;
    end

    assign load_use_stall = |stall_vec;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed per-cycle vectors for fwd_bypass_unit, with instances for load data in M and in W.
module tb_fwd_bypass_unit;

    localparam logic [31:0] REG0 = 32'hAAAA_0000;
    localparam logic [31:0] REG1 = 32'hBBBB_0001;
    localparam logic [31:0] E_V  = 32'h0000_1111;
    localparam logic [31:0] M_V  = 32'h0000_DEAD;
    localparam logic [31:0] W_V  = 32'h0000_3333;

    logic        clk = 1'b0;
    logic        rst, hold, flush_e, d_valid, d_reg_write, d_is_load;
    logic [4:0]  d_rd;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_re;
    logic [63:0] reg_rs_data;
    logic [31:0] e_result, m_result, w_data;
    logic [63:0] rs_data_out2, rs_data_out3;
    logic [3:0]  fwd_sel2, fwd_sel3;
    logic        stall2, stall3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_bypass_unit #(.XLEN(32), .NREAD(2), .RADDR_W(5), .LOAD_DATA_STAGE(2)) u_dut2 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_re(rs_re), .reg_rs_data(reg_rs_data),
        .d_valid(d_valid), .d_rd(d_rd), .d_reg_write(d_reg_write), .d_is_load(d_is_load),
        .flush_e(flush_e), .hold(hold), .e_result(e_result), .m_result(m_result),
        .w_data(w_data), .rs_data_out(rs_data_out2), .fwd_sel(fwd_sel2),
        .load_use_stall(stall2)
    );

    fwd_bypass_unit #(.XLEN(32), .NREAD(2), .RADDR_W(5), .LOAD_DATA_STAGE(3)) u_dut3 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_re(rs_re), .reg_rs_data(reg_rs_data),
        .d_valid(d_valid), .d_rd(d_rd), .d_reg_write(d_reg_write), .d_is_load(d_is_load),
        .flush_e(flush_e), .hold(hold), .e_result(e_result), .m_result(m_result),
        .w_data(w_data), .rs_data_out(rs_data_out3), .fwd_sel(fwd_sel3),
        .load_use_stall(stall3)
    );

    typedef struct {
        logic       rst, hold, flush, dv;
        logic [4:0] drd;
        logic       drw, dld;
        logic       re0;
        logic [4:0] a0;
        logic       re1;
        logic [4:0] a1;
        logic [1:0] s0, s1;
        logic       stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic h, logic f, logic dv, int drd, logic drw,
                               logic dld, logic re0, int a0, logic re1, int a1,
                               int s0, int s1, logic st);
        vec_t t;
        t.rst = r; t.hold = h; t.flush = f; t.dv = dv;
        t.drd = 5'(drd); t.drw = drw; t.dld = dld;
        t.re0 = re0; t.a0 = 5'(a0); t.re1 = re1; t.a1 = 5'(a1);
        t.s0 = 2'(s0); t.s1 = 2'(s1); t.stall = st;
        return t;
    endfunction

    function automatic logic [31:0] exp_data(logic [1:0] sel, logic [31:0] regv);
        case (sel)
            2'd1:    return E_V;
            2'd2:    return M_V;
            2'd3:    return W_V;
            default: return regv;
        endcase
    endfunction

    task automatic check(string name, int id, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step%0d: got %h, expected %h", name, id, act, exp);
        end
    endtask

    task automatic apply(vec_t t, int id, bit use3, bit chk);
        logic [1:0]  sel0, sel1;
        logic [31:0] dat0, dat1;
        logic        st;
        @(negedge clk);
        rst = t.rst; hold = t.hold; flush_e = t.flush; d_valid = t.dv;
        d_rd = t.drd; d_reg_write = t.drw; d_is_load = t.dld;
        rs_re = {t.re1, t.re0}; rs_addr = {t.a1, t.a0};
        #2;
        if (chk) begin
            sel0 = use3 ? fwd_sel3[1:0] : fwd_sel2[1:0];
            sel1 = use3 ? fwd_sel3[3:2] : fwd_sel2[3:2];
            dat0 = use3 ? rs_data_out3[31:0] : rs_data_out2[31:0];
            dat1 = use3 ? rs_data_out3[63:32] : rs_data_out2[63:32];
            st   = use3 ? stall3 : stall2;
            check("sel0", id, 32'(sel0), 32'(t.s0));
            check("sel1", id, 32'(sel1), 32'(t.s1));
            check("data0", id, dat0, exp_data(t.s0, REG0));
            check("data1", id, dat1, exp_data(t.s1, REG1));
            check("stall", id, 32'(st), 32'(t.stall));
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush_e = 1'b0; d_valid = 1'b0; d_rd = '0;
        d_reg_write = 1'b0; d_is_load = 1'b0; rs_re = '0; rs_addr = '0;
        reg_rs_data = {REG1, REG0};
        e_result = E_V; m_result = M_V; w_data = W_V;

        //            r  h  f  dv rd rw ld re0 a0 re1 a1  s0 s1 st
        tbl.push_back(v(1, 0, 0, 1, 5, 1, 0, 1, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 5, 1, 0, 1, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 7, 1, 0, 0, 0, 1, 7, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 7, 1, 0, 0, 0, 1, 7, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 7, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 2, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 3, 1, 1, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 9, 1, 0, 1, 3, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 9, 1, 0, 1, 3, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 9, 3, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 9, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 1, 4, 1, 1, 0, 0, 1, 9, 0, 3, 0));
        tbl.push_back(v(0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 6, 1, 0, 1, 4, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 10, 1, 0, 1, 8, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 10, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 2, 0));

        apply(v(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0, 1'b0);
        foreach (tbl[i]) apply(tbl[i], i, 1'b0, 1'b1);

        // hold freezes the scoreboard; rst then wins over hold
        apply(v(0, 0, 0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0), 100, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            apply(v(0, 1, 0, 1, 15, 1, 0, 1, 14, 1, 15, 1, 0, 0), 101 + k, 1'b0, 1'b1);
        apply(v(0, 0, 0, 0, 0, 0, 0, 1, 14, 1, 15, 1, 0, 0), 104, 1'b0, 1'b1);
        apply(v(0, 0, 0, 0, 0, 0, 0, 1, 14, 1, 15, 2, 0, 0), 105, 1'b0, 1'b1);
        apply(v(1, 1, 0, 0, 0, 0, 0, 1, 14, 0, 0, 3, 0, 0), 106, 1'b0, 1'b1);
        apply(v(0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0), 107, 1'b0, 1'b1);

        // load data only in W: two bubbles back-to-back, one with an independent op between
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1, 1'b1, 1'b0);
        apply(v(0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0), 200, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 9, 1, 0, 1, 3, 0, 0, 1, 0, 1), 201, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 9, 1, 0, 1, 3, 0, 0, 2, 0, 1), 202, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 9, 1, 0, 1, 3, 0, 0, 3, 0, 0), 203, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0), 204, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 20, 1, 0, 0, 0, 1, 9, 0, 2, 0), 205, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 21, 1, 0, 1, 4, 1, 20, 2, 1, 1), 206, 1'b1, 1'b1);
        apply(v(0, 0, 0, 1, 21, 1, 0, 1, 4, 1, 20, 3, 2, 0), 207, 1'b1, 1'b1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
